encode_header: RTL
==================

ENCODE_HEADER -- requirements
Module: encode_header

Interface
REQ-001 clock  input  1  single rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 Header_Start_I  input  1  request one frame header; sampled only in IDLE.
REQ-004 Header_Done_O  output  1  high while in IDLE.
REQ-005 Bitrate_Index_I  input  4  Layer II bitrate index; 1..14 = 32,48,56,64,80,96,112,128,160,192,224,256,320,384 kbps.
REQ-006 Sample_Freq_I  input  2  00=44.1k, 01=48k, 10=32k, 11 reserved.
REQ-007 Mode_I, Mode_Ext_I  input  2 each  channel mode and mode extension fields.
REQ-008 Copyright_I, Original_I  input  1 each; Emphasis_I  input  2  header flag fields.
REQ-009 Protect_I  input  1  1 = CRC follows header (protection_bit written as 0).
REQ-010 Bitstream_Data_O  output  16  header word, MSB first in stream.
REQ-011 Bitstream_Valid_O  output  1; Bitstream_Ready_I  input  1  word handshake.
REQ-012 Frame_Bytes_O  output  11  total frame length in bytes incl. padding; Padding_O  output  1.
REQ-013 Format_Error_O  output  1  one-cycle pulse when a request is rejected.

Function
REQ-014 States SHALL be IDLE, CALC, WORD0, WORD1.
REQ-015 IDLE: on Header_Start_I, all field inputs SHALL be latched and state -> CALC; start in any other state SHALL be ignored.
REQ-016 CALC (one cycle): if index is 0 or 15, or Sample_Freq is 11, SHALL pulse Format_Error_O, leave accumulator unchanged, return to IDLE with no words emitted.
REQ-017 CALC otherwise SHALL register Frame_Bytes_O and Padding_O, then -> WORD0.
REQ-018 Frame length: 48k = 3*kbps; 32k = 9*kbps/2 (exact for all legal rates); padding 0 for both.
REQ-019 44.1k: base = floor(144000*kbps/44100), rem = remainder, both from constant tables; sum = acc + rem; if sum >= 44100 then Padding=1, acc = sum-44100, else Padding=0, acc = sum; length = base + Padding.
REQ-020 Accumulator SHALL be 17 bits, cleared by reset only, updated only on accepted 44.1k requests.
REQ-021 WORD0 = {12'hFFF, 1'b1, 2'b10, ~Protect_I}.
REQ-022 WORD1 = {bitrate_index, sample_freq, padding, 1'b0, mode, mode_ext, copyright, original, emphasis}.
REQ-023 Bitstream_Valid_O SHALL be high exactly in WORD0 and WORD1; a word transfers on Valid & Ready.
REQ-024 While Valid & ~Ready, Bitstream_Data_O SHALL hold stable and state SHALL not advance.
REQ-025 WORD0 -> WORD1 and WORD1 -> IDLE on transfer; minimum latency start-to-first-valid = 2 cycles, start-to-done = 4 cycles.
REQ-026 Frame_Bytes_O and Padding_O SHALL hold their value until the next accepted CALC.

Reset
REQ-027 Reset SHALL force IDLE, Valid 0, Format_Error 0, Data 0, Frame_Bytes 0, Padding 0, accumulator 0, latched fields 0.
REQ-028 Reset mid-transfer SHALL abandon the header; no further words are emitted.
REQ-029 Reset dominates Header_Start_I in the same cycle.

Structure
REQ-030 State encodings, bitrate kbps table, 44.1k base/remainder tables and the 44100 constant SHALL live in the shared defines file.
REQ-031 The padding/length calculator SHALL be one sub-module, mp2_frame_length, purely registered on a load strobe.

Verification
REQ-032 48k, index 10, Protect 0, mode 00, others 0, Ready=1 -> words 0xFFFD, 0xA400; Frame_Bytes 576, Padding 0.
REQ-033 44.1k, index 8, three back-to-back frames -> lengths 417, 418, 418; Padding 0,1,1; accumulator 38700 after third.
REQ-034 32k, index 14, Protect 1 -> WORD0 0xFFFC; Frame_Bytes 1728.
REQ-035 Index 15 (or fs 11) -> Format_Error pulse one cycle, no Valid, Header_Done returns high, accumulator unchanged.
REQ-036 Ready low for 3 cycles during WORD0 -> Data held 0xFFFD, state held; completes after Ready rises.
REQ-037 Reset asserted in WORD1 -> next cycle IDLE, Valid 0, outputs zero; Header_Start during WORD0 ignored.

Source files
------------

// File: rtl/encode_header_pkg.sv
// Shared definitions for the MPEG-1 Layer II header encoder: state encodings,
// sample-rate codes and the bitrate / 44.1 kHz frame-length tables.
package encode_header_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WORD0 = 2'd2,
        ST_WORD1 = 2'd3
    } header_state_t;

    localparam logic [1:0] FS_44K      = 2'b00;
    localparam logic [1:0] FS_48K      = 2'b01;
    localparam logic [1:0] FS_32K      = 2'b10;
    localparam logic [1:0] FS_RESERVED = 2'b11;

    // The 44.1 kHz padding accumulator counts in units of 1/44100 byte.
    localparam logic [16:0] FS_441_UNITS = 17'd44100;

    // Layer II bitrate in kbps, indexed by the header bitrate field.
    localparam logic [8:0] KBPS_TABLE [16] = '{
        9'd0,   9'd32,  9'd48,  9'd56,  9'd64,  9'd80,  9'd96,  9'd112,
        9'd128, 9'd160, 9'd192, 9'd224, 9'd256, 9'd320, 9'd384, 9'd0
    };

    // floor(144000 * kbps / 44100) for each bitrate index.
    localparam logic [10:0] BASE_441_TABLE [16] = '{
        11'd0,   11'd104, 11'd156, 11'd182, 11'd208, 11'd261,  11'd313,  11'd365,
        11'd417, 11'd522, 11'd626, 11'd731, 11'd835, 11'd1044, 11'd1253, 11'd0
    };

    // (144000 * kbps) mod 44100 for each bitrate index.
    localparam logic [15:0] REM_441_TABLE [16] = '{
        16'd0,     16'd21600, 16'd32400, 16'd37800, 16'd43200, 16'd9900,  16'd20700, 16'd31500,
        16'd42300, 16'd19800, 16'd41400, 16'd18900, 16'd40500, 16'd39600, 16'd38700, 16'd0
    };

    // Free-format (0), forbidden (15) and reserved sample rate cannot be encoded.
    function automatic logic is_bad_request(input logic [3:0] bitrate_index,
                                            input logic [1:0] sample_freq);
        return (bitrate_index == 4'd0) || (bitrate_index == 4'd15) ||
               (sample_freq == FS_RESERVED);
    endfunction

endpackage

// File: rtl/mp2_frame_length.sv
// Frame length and padding calculator. Everything updates only on a load
// strobe; the 44.1 kHz accumulator carries fractional bytes between frames.
module mp2_frame_length
    import encode_header_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [3:0]  bitrate_index,
    input  logic [1:0]  sample_freq,
    output logic [10:0] frame_bytes,
    output logic        padding
);

    logic [16:0] acc;
    logic [8:0]  kbps;
    logic [10:0] base_441;
    logic [16:0] sum_441;
    logic        wrap_441;
    logic [10:0] bytes_48k;
    logic [10:0] bytes_32k;

    // Table lookups and the candidate lengths for each sample rate; every legal
    // kbps value is even, so 9*kbps/2 is exactly 4*kbps + kbps/2.
    always_comb begin
        kbps      = KBPS_TABLE[bitrate_index];
        base_441  = BASE_441_TABLE[bitrate_index];
        sum_441   = acc + {1'b0, REM_441_TABLE[bitrate_index]};
        wrap_441  = (sum_441 >= FS_441_UNITS);
        bytes_48k = {2'b00, kbps} * 11'd3;
        bytes_32k = {kbps, 2'b00} + {3'b000, kbps[8:1]};
    end

    // Register the new length, padding and accumulator when a frame is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc         <= '0;
            frame_bytes <= '0;
            padding     <= 1'b0;
        end else if (load) begin
            case (sample_freq)
                FS_48K: begin
                    frame_bytes <= bytes_48k;
                    padding     <= 1'b0;
                end
                FS_32K: begin
                    frame_bytes <= bytes_32k;
                    padding     <= 1'b0;
                end
                FS_44K: begin
                    if (wrap_441) begin
                        acc         <= sum_441 - FS_441_UNITS;
                        frame_bytes <= base_441 + 11'd1;
                        padding     <= 1'b1;
                    end else begin
                        acc         <= sum_441;
                        frame_bytes <= base_441;
                        padding     <= 1'b0;
                    end
                end
                default: begin
                    frame_bytes <= frame_bytes;
                    padding     <= padding;
                end
            endcase
        end
    end

endmodule

// File: rtl/encode_header.sv
// MPEG-1 Layer II frame header encoder: latches the header fields on request,
// validates them, computes the frame length and emits two 16-bit header words.
module encode_header
    import encode_header_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        Header_Start_I,
    output logic        Header_Done_O,
    input  logic [3:0]  Bitrate_Index_I,
    input  logic [1:0]  Sample_Freq_I,
    input  logic [1:0]  Mode_I,
    input  logic [1:0]  Mode_Ext_I,
    input  logic        Copyright_I,
    input  logic        Original_I,
    input  logic [1:0]  Emphasis_I,
    input  logic        Protect_I,
    output logic [15:0] Bitstream_Data_O,
    output logic        Bitstream_Valid_O,
    input  logic        Bitstream_Ready_I,
    output logic [10:0] Frame_Bytes_O,
    output logic        Padding_O,
    output logic        Format_Error_O
);

    header_state_t state_q;
    header_state_t state_d;

    logic [3:0] bitrate_index_q;
    logic [1:0] sample_freq_q;
    logic [1:0] mode_q;
    logic [1:0] mode_ext_q;
    logic       copyright_q;
    logic       original_q;
    logic [1:0] emphasis_q;
    logic       protect_q;

    logic       request_bad;
    logic       transfer;
    logic       length_load;

    assign request_bad = is_bad_request(bitrate_index_q, sample_freq_q);
    assign transfer    = Bitstream_Valid_O & Bitstream_Ready_I;

    // State register; reset wins over any pending start request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the header fields only when a request is accepted in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            bitrate_index_q <= '0;
            sample_freq_q   <= '0;
            mode_q          <= '0;
            mode_ext_q      <= '0;
            copyright_q     <= 1'b0;
            original_q      <= 1'b0;
            emphasis_q      <= '0;
            protect_q       <= 1'b0;
        end else if ((state_q == ST_IDLE) && Header_Start_I) begin
            bitrate_index_q <= Bitrate_Index_I;
            sample_freq_q   <= Sample_Freq_I;
            mode_q          <= Mode_I;
            mode_ext_q      <= Mode_Ext_I;
            copyright_q     <= Copyright_I;
            original_q      <= Original_I;
            emphasis_q      <= Emphasis_I;
            protect_q       <= Protect_I;
        end
    end

    // Next-state logic: words advance only on a completed handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Header_Start_I) state_d = ST_CALC;
            ST_CALC:  state_d = request_bad ? ST_IDLE : ST_WORD0;
            ST_WORD0: if (transfer) state_d = ST_WORD1;
            ST_WORD1: if (transfer) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode: the data word is a pure function of state and latched fields.
    always_comb begin
        Header_Done_O     = 1'b0;
        Bitstream_Valid_O = 1'b0;
        Bitstream_Data_O  = '0;
        Format_Error_O    = 1'b0;
        length_load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                Header_Done_O = 1'b1;
            end
            ST_CALC: begin
                Format_Error_O = request_bad;
                length_load    = ~request_bad;
            end
            ST_WORD0: begin
                Bitstream_Valid_O = 1'b1;
                Bitstream_Data_O  = {12'hFFF, 1'b1, 2'b10, ~protect_q};
            end
            ST_WORD1: begin
                Bitstream_Valid_O = 1'b1;
                Bitstream_Data_O  = {bitrate_index_q, sample_freq_q, Padding_O, 1'b0,
                                     mode_q, mode_ext_q, copyright_q, original_q,
                                     emphasis_q};
            end
            default: begin
                Header_Done_O = 1'b0;
            end
        endcase
    end

    mp2_frame_length u_frame_length (
        .clock         (clock),
        .reset         (reset),
        .load          (length_load),
        .bitrate_index (bitrate_index_q),
        .sample_freq   (sample_freq_q),
        .frame_bytes   (Frame_Bytes_O),
        .padding       (Padding_O)
    );

endmodule
